muldiv_seq: RTL and testbench

Issue-side sequencer for the iterative multiply/divide unit. It accepts a MULT/DIV request from the CPU control path, captures the operands, and drives the unit's op/operand/reset inputs. It waits for the unit's Done, commits the result into the architectural HI/LO registers, and reports divide-by-zero. It sits between the control FSM / register file and the mult/div datapath, and owns HI/LO plus their MTHI/MTLO write path.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/hilo_regs.sv | 36 +++
 rtl/muldiv_seq.sv | 151 +++++++++++++++
 tb/tb_muldiv_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide issue sequencer.
package muldiv_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_WAIT  = 2'd2
    } seq_state_t;

    // Unit HDControl encodings
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // Accept-edge to commit-edge latencies
    localparam int unsigned MULT_LATENCY = 36;
    localparam int unsigned DIV0_LATENCY = 3;

    // A finished operation updates HI/LO unless it is a divide by zero
    function automatic logic commit_ok(input logic op, input logic divby0);
        return (op == OP_MULT) || !divby0;
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO registers: unit commit port plus MTHI/MTLO write port.
// A commit takes priority over a same-cycle MTHI/MTLO write.
module hilo_regs (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_commit,
    input  logic [31:0] i_commit_hi,
    input  logic [31:0] i_commit_lo,
    input  logic        i_wr_hi,
    input  logic        i_wr_lo,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // HI/LO update: commit first, otherwise independent MTHI/MTLO strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_commit) begin
            r_hi <= i_commit_hi;
            r_lo <= i_commit_lo;
        end else begin
            if (i_wr_hi) r_hi <= i_wr_data;
            if (i_wr_lo) r_lo <= i_wr_data;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_seq.sv
// Issue-side sequencer for the iterative multiply/divide unit.
// Captures a MULT/DIV request, resets the unit for one cycle, waits for Done,
// then commits into HI/LO or flags divide-by-zero.
// Optional watchdog: define MULDIV_SEQ_TIMEOUT_EN to abort WAIT after
// TIMEOUT_CYCLES cycles; otherwise WAIT is unbounded and timeout is tied 0.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic        md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_rst,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    input  logic        md_divby0,
    input  logic        md_done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        op_done,
    output logic        div0_exc,
    output logic        timeout
);

    seq_state_t  r_state;
    logic        r_md_op;
    logic [31:0] r_md_a;
    logic [31:0] r_md_b;
    logic        r_op_done;
    logic        r_div0_exc;
    logic        r_timeout;

    logic        w_commit;
    logic        w_wr_hi;
    logic        w_wr_lo;

    assign w_commit = (r_state == S_WAIT) && md_done && commit_ok(r_md_op, md_divby0);
    assign w_wr_hi  = (r_state == S_IDLE) && wr_hi;
    assign w_wr_lo  = (r_state == S_IDLE) && wr_lo;

`ifdef MULDIV_SEQ_TIMEOUT_EN
    logic [31:0] r_wdog;
    logic        r_abort;
    logic        w_expire;

    // Count reaches the limit at the edge ending the last permitted WAIT cycle
    assign w_expire = ((r_wdog + 32'd1) == TIMEOUT_CYCLES);
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    // Sequencer FSM with registered operand capture and result pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_md_op    <= OP_MULT;
            r_md_a     <= '0;
            r_md_b     <= '0;
            r_op_done  <= 1'b0;
            r_div0_exc <= 1'b0;
            r_timeout  <= 1'b0;
`ifdef MULDIV_SEQ_TIMEOUT_EN
            r_wdog     <= '0;
            r_abort    <= 1'b0;
`endif
        end else begin
            r_op_done  <= 1'b0;
            r_div0_exc <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_md_op <= req_op;
                        r_md_a  <= req_a;
                        r_md_b  <= req_b;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
`ifdef MULDIV_SEQ_TIMEOUT_EN
                    // CLEAR doubles as the unit reset after a watchdog abort
                    if (r_abort) begin
                        r_abort <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog  <= '0;
                        r_state <= S_WAIT;
                    end
`else
                    r_state <= S_WAIT;
`endif
                end
                S_WAIT: begin
                    if (md_done) begin
                        if (commit_ok(r_md_op, md_divby0)) r_op_done <= 1'b1;
                        else                               r_div0_exc <= 1'b1;
                        r_state <= S_IDLE;
                    end
`ifdef MULDIV_SEQ_TIMEOUT_EN
                    else if (w_expire) begin
                        r_timeout <= 1'b1;
                        r_abort   <= 1'b1;
                        r_state   <= S_CLEAR;
                    end else begin
                        r_wdog <= r_wdog + 32'd1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    hilo_regs u_hilo (
        .clock       (clock),
        .reset       (reset),
        .i_commit    (w_commit),
        .i_commit_hi (md_hi),
        .i_commit_lo (md_lo),
        .i_wr_hi     (w_wr_hi),
        .i_wr_lo     (w_wr_lo),
        .i_wr_data   (wr_data),
        .o_hi        (hi),
        .o_lo        (lo)
    );

    assign req_ready = (r_state == S_IDLE) && !reset;
    assign busy      = (r_state != S_IDLE);
    assign md_rst    = reset || (r_state == S_CLEAR);
    assign md_op     = r_md_op;
    assign md_a      = r_md_a;
    assign md_b      = r_md_b;
    assign op_done   = r_op_done;
    assign div0_exc  = r_div0_exc;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq with a behavioural mult/div unit beside it.
// Expected results are pushed at issue time and checked when a pulse appears.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_op = 1'b0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_ready;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wr_data = '0;
    logic        md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_rst;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_divby0;
    logic        md_done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        op_done;
    logic        div0_exc;
    logic        timeout;

    always #5 clock = ~clock;

    muldiv_seq #(.TIMEOUT_CYCLES(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wr_data   (wr_data),
        .md_op     (md_op),
        .md_a      (md_a),
        .md_b      (md_b),
        .md_rst    (md_rst),
        .md_hi     (md_hi),
        .md_lo     (md_lo),
        .md_divby0 (md_divby0),
        .md_done   (md_done),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .op_done   (op_done),
        .div0_exc  (div0_exc),
        .timeout   (timeout)
    );

    // ---------------- behavioural mult/div unit ----------------
    // Init on first edge out of reset; MULT Done 33 edges later, DIV Done
    // q+1 edges later, divide by zero Done on the init edge. Done drops on
    // the following edge. DivBy0 is only rewritten on the divide path.
    logic        u_init, u_run;
    logic [31:0] u_cnt;
    logic [31:0] u_hi, u_lo;
    logic        u_done, u_div0;

    always @(posedge clock) begin
        if (md_rst) begin
            u_init <= 1'b1;
            u_run  <= 1'b0;
            u_done <= 1'b0;
        end else if (u_init) begin
            u_init <= 1'b0;
            if (md_op == OP_DIV && md_b == 32'd0) begin
                u_done <= 1'b1;
                u_div0 <= 1'b1;
            end else if (md_op == OP_DIV) begin
                u_div0 <= 1'b0;
                u_lo   <= 32'($signed(md_a) / $signed(md_b));
                u_hi   <= 32'($signed(md_a) % $signed(md_b));
                u_cnt  <= ($signed(md_a) / $signed(md_b)) < 0 ?
                          32'(-($signed(md_a) / $signed(md_b))) :
                          32'($signed(md_a) / $signed(md_b));
                u_run  <= 1'b1;
            end else begin
                {u_hi, u_lo} <= 64'(longint'($signed(md_a)) * longint'($signed(md_b)));
                u_cnt <= 32'd32;
                u_run <= 1'b1;
            end
        end else if (u_run) begin
            if (u_cnt == 32'd0) begin
                u_done <= 1'b1;
                u_run  <= 1'b0;
            end else begin
                u_cnt <= u_cnt - 32'd1;
            end
        end else if (u_done) begin
            u_done <= 1'b0;
        end
    end

    assign md_done   = u_done;
    assign md_divby0 = u_div0;
    assign md_hi     = u_hi;
    assign md_lo     = u_lo;

    // ---------------- scoreboard ----------------
    localparam logic [2:0] K_COMMIT  = 3'b100;
    localparam logic [2:0] K_DIV0    = 3'b010;
    localparam logic [2:0] K_TIMEOUT = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_rst = 0;
    logic        prev_pulse = 1'b0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pulse kind, HI/LO and latency against the oldest expectation
    always @(negedge clock) begin
        if (md_rst) n_rst++;
        if (!reset && (op_done || div0_exc || timeout)) begin
            if (prev_pulse) check("pulse_width", 64'd2, 64'd1);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {61'd0, op_done, div0_exc, timeout}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result_kind", {61'd0, op_done, div0_exc, timeout}, {61'd0, mon_e.kind});
                check("result_hi", {32'd0, hi}, {32'd0, mon_e.hi});
                check("result_lo", {32'd0, lo}, {32'd0, mon_e.lo});
                check("result_latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
        end
        prev_pulse = op_done || div0_exc || timeout;
    end

    // Drive one request, predict its outcome, check the CLEAR cycle
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p, q;
        check("req_ready_before_issue", {63'd0, req_ready}, 64'd1);
        if (op == OP_MULT) begin
            p = longint'($signed(a)) * longint'($signed(b));
            exp_hi = p[63:32];
            exp_lo = p[31:0];
            e.kind = K_COMMIT;
            e.lat  = int'(MULT_LATENCY);
        end else if (b == 32'd0) begin
            e.kind = K_DIV0;
            e.lat  = int'(DIV0_LATENCY);
        end else begin
            q = longint'($signed(a) / $signed(b));
            if (q < 0) q = -q;
            e.kind = K_COMMIT;
            e.lat  = 4 + int'(q);
`ifdef MULDIV_SEQ_TIMEOUT_EN
            // 64 WAIT cycles after the CLEAR edge A+1 -> abort at A+65
            if (q > 60) begin
                e.kind = K_TIMEOUT;
                e.lat  = 65;
            end
`endif
            if (e.kind == K_COMMIT) begin
                exp_lo = 32'($signed(a) / $signed(b));
                exp_hi = 32'($signed(a) % $signed(b));
            end
        end
        e.hi = exp_hi;
        e.lo = exp_lo;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clock);
        e.acc = cyc;
        sb.push_back(e);
        req_valid = 1'b0;
        req_a     = ~a;
        req_b     = ~b;
        check("clear_md_rst", {63'd0, md_rst}, 64'd1);
        check("clear_busy", {63'd0, busy}, 64'd1);
        check("clear_req_ready", {63'd0, req_ready}, 64'd0);
        check("clear_operands", {31'd0, md_op, md_a, md_b}, {31'd0, op, a, b});
    endtask

    // Bounded wait for all expected results and a return to IDLE
    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while ((sb.size() != 0 || busy) && n < budget);
        check({tag, "_completed"}, {63'd0, (sb.size() == 0 && !busy)}, 64'd1);
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    int rst0;

    initial begin
        // Reset
        repeat (3) @(negedge clock);
        check("reset_req_ready", {63'd0, req_ready}, 64'd0);
        check("reset_md_rst", {63'd0, md_rst}, 64'd1);
        #1 reset = 1'b0;
        @(negedge clock);
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_flags", {59'd0, busy, op_done, div0_exc, timeout, md_rst}, 64'd0);
        check("reset_operands", {31'd0, md_op, md_a, md_b}, 64'd0);
        check("reset_req_ready_released", {63'd0, req_ready}, 64'd1);

        // MULT 7 x -3, md_rst high for exactly one cycle
        rst0 = n_rst;
        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        wait_idle("mult_7x-3", 60);
        check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mult_md_rst_cycles", 64'(n_rst - rst0), 64'd1);

        // DIV 7 / -3, then DIV -7 / -3 in the first IDLE cycle after commit
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFD);
        wait_idle("div_7/-3", 30);
        check("div1_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFD);
        wait_idle("div_-7/-3", 30);
        check("div2_hilo", {hi, lo}, 64'hFFFF_FFFF_0000_0002);

        // MTHI in IDLE, then DIV by zero leaves HI/LO alone
        wr_hi = 1'b1;
        wr_data = 32'h1234_5678;
        exp_hi = 32'h1234_5678;
        @(negedge clock);
        #1 wr_hi = 1'b0;
        check("mthi_idle", {32'd0, hi}, {32'd0, 32'h1234_5678});
        issue(OP_DIV, 32'd5, 32'd0);
        wait_idle("div_by_zero", 20);
        check("div0_hi_kept", {32'd0, hi}, {32'd0, 32'h1234_5678});

        // MULT with MTHI/MTLO and extra requests while busy; stale DivBy0 ignored
        issue(OP_MULT, 32'h0001_2345, 32'hFFFF_6789);
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_op = OP_DIV;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clock);
            check("busy_req_ready", {63'd0, req_ready}, 64'd0);
            check("busy_mt_ignored_lo", {32'd0, lo}, 64'd2);
        end
        #1;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        req_valid = 1'b0;
        wait_idle("mult_busy_writes", 60);
        check("mult_busy_lo", {32'd0, lo}, {32'd0, exp_lo});
        repeat (3) @(negedge clock);
        check("no_hidden_accept", {63'd0, busy}, 64'd0);

        // Reset 10 cycles into a MULT abandons it
        #1;
        issue(OP_MULT, 32'h0000_1111, 32'h0000_2222);
        repeat (9) @(negedge clock);
        #1 reset = 1'b1;
        sb.delete();
        @(negedge clock);
        #1 reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("midop_reset_hilo", {hi, lo}, 64'd0);
        check("midop_reset_busy", {63'd0, busy}, 64'd0);
        repeat (45) @(negedge clock);
        #1;
        issue(OP_MULT, 32'd3, 32'd4);
        wait_idle("mult_3x4", 60);
        check("mult_3x4_hilo", {hi, lo}, 64'd12);

`ifdef MULDIV_SEQ_TIMEOUT_EN
        // Watchdog abort of a very long divide
        rst0 = n_rst;
        issue(OP_DIV, 32'h7FFF_FFFF, 32'd1);
        wait_idle("div_timeout", 120);
        check("timeout_hilo", {hi, lo}, 64'd12);
        check("timeout_md_rst_cycles", 64'(n_rst - rst0), 64'd2);
        check("timeout_req_ready", {63'd0, req_ready}, 64'd1);
`else
        check("timeout_tied_low", {63'd0, timeout}, 64'd0);
`endif

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
